// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register with a valid/ready handshake.
// A main entry (M) drives the outputs. A skid entry (S) absorbs the one beat
// that arrives while the downstream stage stalls. in_ready comes from a flop,
// so the ready chain does not ripple combinationally through the pipeline.
// Control bits read as zero on bubbles, so an empty stage cannot trigger a
// write or a memory access downstream.
module pipe_stage_skid #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [STALL_W-1:0] stall_cnt
);

  // Encodings are chosen so that bit 0 is M.valid and bit 1 is S.valid.
  // The illegal combination "S valid, M empty" (2'b10) has no name.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_t;

  occ_t              state;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              in_ready_q;

  logic acc;
  logic pop;
  logic m_valid;

  // Occupancy decode and handshake qualifiers. These are bit selects of flops
  // gated only by the handshake inputs, so no input reaches an output.
  always_comb begin
    m_valid = state[0];
    acc     = in_valid && in_ready_q;
    pop     = m_valid && out_ready;
  end

  // Occupancy FSM, entry storage and stall counter. Priority: reset, then flush, then normal.
  always_ff @(posedge clk) begin
    // NOTE: every sequential update uses <= so that all flops sample the pre-edge values of acc/pop/state together.
    if (!reset_n) begin
      state      <= EMPTY;
      m_ctrl     <= '0;
      m_data     <= '0;
      s_ctrl     <= '0;
      s_data     <= '0;
      in_ready_q <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      // The stall counter ignores flush and saturates at all-ones.
      if (m_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        // Kill both entries. Data flops keep their values because the cleared
        // valid bits and ctrl fields already make the stale payload harmless.
        state      <= EMPTY;
        m_ctrl     <= '0;
        s_ctrl     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              m_ctrl <= in_ctrl;
              m_data <= in_data;
              state  <= ONE;
            end
          end
          ONE: begin
            if (acc && pop) begin
              m_ctrl <= in_ctrl;
              m_data <= in_data;
            end else if (acc) begin
              s_ctrl     <= in_ctrl;
              s_data     <= in_data;
              state      <= FULL;
              in_ready_q <= 1'b0;
            end else if (pop) begin
              m_ctrl <= '0;
              state  <= EMPTY;
            end
          end
          FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
              m_ctrl     <= s_ctrl;
              m_data     <= s_data;
              s_ctrl     <= '0;
              state      <= ONE;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            // Unreachable encoding: recover to a clean empty stage.
            state      <= EMPTY;
            m_ctrl     <= '0;
            s_ctrl     <= '0;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Output drive. The ctrl gate keeps out_ctrl at zero even if a stale ctrl value were left in M.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = m_valid;
    out_ctrl  = m_valid ? m_ctrl : '0;
    out_data  = m_data;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard bench for pipe_stage_skid.
// The main instance uses the default widths. A second instance with a 4-bit
// stall counter exercises saturation.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [15:0] stall_cnt;

  logic        sat_in_valid;
  logic        sat_in_ready;
  logic [1:0]  sat_in_ctrl;
  logic [7:0]  sat_in_data;
  logic        sat_out_valid;
  logic        sat_out_ready;
  logic [1:0]  sat_out_ctrl;
  logic [7:0]  sat_out_data;
  logic [3:0]  sat_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(2), .STALL_W(4)) dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (1'b0),
    .in_valid  (sat_in_valid),
    .in_ready  (sat_in_ready),
    .in_ctrl   (sat_in_ctrl),
    .in_data   (sat_in_data),
    .out_valid (sat_out_valid),
    .out_ready (sat_out_ready),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .stall_cnt (sat_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  logic [63:0] qd[$];
  logic [7:0]  qc[$];
  logic        acc;
  logic        pop;
  logic        held;

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 64'h0);
    sat_in_valid = 1'b0; sat_in_ctrl = 2'b00; sat_in_data = 8'h00; sat_out_ready = 1'b0;
    tick(); tick();

    // Reset state.
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl",  out_ctrl,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_stall",     stall_cnt, 0);
    reset_n = 1'b1;

    // Streaming at full rate.
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 64'h11); tick();
    check("stream_d0", out_data, 64'h11);
    check("stream_v0", out_valid, 1);
    check("stream_r0", in_ready, 1);
    drive(1'b1, 8'h02, 64'h22); tick();
    check("stream_d1", out_data, 64'h22);
    check("stream_r1", in_ready, 1);
    drive(1'b1, 8'h03, 64'h33); tick();
    check("stream_d2", out_data, 64'h33);
    check("stream_c2", out_ctrl, 8'h03);
    drive(1'b0, 8'h00, 64'h0); tick();
    check("stream_drain_v", out_valid, 0);
    check("stream_drain_c", out_ctrl, 0);
    check("stream_stall", stall_cnt, 0);

    // Fill to FULL under back-pressure, then drain.
    out_ready = 1'b0;
    drive(1'b1, 8'h81, 64'hA); tick();
    check("fill_one_d", out_data, 64'hA);
    check("fill_one_c", out_ctrl, 8'h81);
    check("fill_one_r", in_ready, 1);
    drive(1'b1, 8'h05, 64'hB); tick();
    check("full_r", in_ready, 0);
    check("full_d", out_data, 64'hA);
    drive(1'b0, 8'h00, 64'h0); tick();
    check("full_hold_d", out_data, 64'hA);
    check("full_hold_c", out_ctrl, 8'h81);
    check("full_stall2", stall_cnt, 2);
    out_ready = 1'b1; tick();
    check("pop1_d", out_data, 64'hB);
    check("pop1_c", out_ctrl, 8'h05);
    check("pop1_r", in_ready, 1);
    check("pop1_stall", stall_cnt, 2);
    tick();
    check("pop2_v", out_valid, 0);
    check("pop2_c", out_ctrl, 0);

    // Flush a FULL stage while a beat is offered.
    out_ready = 1'b0;
    drive(1'b1, 8'h03, 64'hC1); tick();
    drive(1'b1, 8'h07, 64'hC2); tick();
    check("fl_full_r", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 8'hFF, 64'hDD); tick();
    check("fl_v", out_valid, 0);
    check("fl_c", out_ctrl, 0);
    check("fl_r", in_ready, 1);
    check("fl_stall", stall_cnt, 4);
    flush = 1'b0;
    drive(1'b0, 8'h00, 64'h0);
    out_ready = 1'b1; tick();
    check("fl_dropped_v", out_valid, 0);
    check("fl_dropped_c", out_ctrl, 0);

    // Reset together with flush on a FULL stage.
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 64'hE1); tick();
    drive(1'b1, 8'h02, 64'hE2); tick();
    check("rf_full_r", in_ready, 0);
    reset_n = 1'b0; flush = 1'b1;
    drive(1'b0, 8'h00, 64'h0); tick();
    check("rf_in_ready",  in_ready,  1);
    check("rf_out_valid", out_valid, 0);
    check("rf_out_ctrl",  out_ctrl,  0);
    check("rf_out_data",  out_data,  0);
    check("rf_stall",     stall_cnt, 0);
    reset_n = 1'b1; flush = 1'b0;
    tick();
    check("rf_after_v", out_valid, 0);

    // Saturation of a 4-bit stall counter.
    sat_in_valid = 1'b1; sat_in_ctrl = 2'b01; sat_in_data = 8'h5A; tick();
    sat_in_valid = 1'b0;
    check("sat_start", sat_stall_cnt, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("sat_14", sat_stall_cnt, 14);
      if (k == 15) check("sat_15", sat_stall_cnt, 15);
    end
    check("sat_hold", sat_stall_cnt, 15);
    check("sat_data", sat_out_data, 8'h5A);

    // Random handshake traffic against a FIFO scoreboard.
    held = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!held) drive(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom});
      out_ready = 1'($urandom_range(0, 1));
      if (!out_valid) check("rnd_ctrl_zero", out_ctrl, 0);
      check("rnd_in_ready", in_ready, (qd.size() < 2) ? 1 : 0);
      check("rnd_out_valid", out_valid, (qd.size() > 0) ? 1 : 0);
      acc  = in_valid && in_ready;
      pop  = out_valid && out_ready;
      held = in_valid && !in_ready;
      if (pop && qd.size() > 0) begin
        check("rnd_data", out_data, qd[0]);
        check("rnd_ctrl", out_ctrl, qc[0]);
      end
      tick();
      if (pop && qd.size() > 0) begin
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
      if (acc) begin
        qd.push_back(in_data);
        qc.push_back(in_ctrl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
